rx_shift_ctrl: RTL and testbench

Sequencer for the receive-side 8-bit serial-in/parallel-out shift register (LSB-first).
- Generates mid-bit shift_enable strobes from a clock-count bit timer, resynchronised on every line edge.
- Removes stuffed bits (one bit dropped after 6 consecutive ones).
- Counts bits and pulses byte_received once 8 data bits sit in the register.
- Driven by the receiver FSM through enable_timer; its outputs feed the shift register and the RX FSM.

---
 rtl/rx_ctrl_pkg.sv | 18 +
 rtl/rx_bit_timer.sv | 57 +++++
 rtl/rx_shift_ctrl.sv | 152 +++++++++++++++
 tb/tb_rx_shift_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_ctrl_pkg.sv
// Shared types and constants for the receive-side shift-register sequencer.
//
// Contents:
//   rx_ctrl_state_t      sequencer state (IDLE, RUN, DONE)
//   BYTE_BITS            data bits per received byte
//   STUFF_LIMIT_DEFAULT  consecutive data ones after which a stuff bit follows
package rx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } rx_ctrl_state_t;

  localparam int unsigned BYTE_BITS           = 8;
  localparam int unsigned STUFF_LIMIT_DEFAULT = 6;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit timer for the receive sequencer: a clock-count phase counter that is
// resynchronised on every decoded-line edge and produces the mid-bit sample
// strobe.
//
// Ports:
//   clk     in   system clock, rising edge
//   n_rst   in   asynchronous active-low reset
//   active  in   timer runs while high; counter held at 0 while low
//   d_edge  in   one-cycle pulse on any decoded-line transition
//   sample  out  mid-bit sample strobe (combinational from registered count)
module rx_bit_timer
  import rx_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_POINT = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic active,
  input  logic d_edge,
  output logic sample
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] LastCnt   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] SampleCnt = CntW'(SAMPLE_POINT);

  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;

  // The edge cycle itself counts as phase 0, so a resync loads 1 for the
  // following cycle. Resync takes priority over the normal increment/wrap.
  always_comb begin
    clk_cnt_d = clk_cnt_q;
    if (!active) begin
      clk_cnt_d = '0;
    end else if (d_edge) begin
      clk_cnt_d = CntW'(1);
    end else if (clk_cnt_q == LastCnt) begin
      clk_cnt_d = '0;
    end else begin
      clk_cnt_d = clk_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      clk_cnt_q <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
    end
  end

  // An edge landing on the sample point wins: the bit is sampled after the
  // resync instead, so it is neither lost nor doubled.
  assign sample = active && (clk_cnt_q == SampleCnt) && !d_edge;

endmodule

// File: rtl/rx_shift_ctrl.sv
// Sequencer for the receive-side 8-bit serial-in/parallel-out shift register
// (LSB first). Generates mid-bit shift strobes, drops stuffed bits, counts
// data bits and flags each completed byte.
//
// Ports:
//   clk            in   system clock, rising edge
//   n_rst          in   asynchronous active-low reset
//   enable_timer   in   from RX FSM; high while a packet is being received
//   d_edge         in   one-cycle pulse on any decoded-line transition
//   d_orig         in   decoded serial bit (same signal the shift register samples)
//   shift_enable   out  one-cycle strobe to the shift register
//   byte_received  out  one-cycle pulse, byte complete in the shift register
//   bit_count      out  data bits shifted into the current byte, 0..7
//   stuff_err      out  sticky stuff-bit violation flag
//
// Build option: define RX_STUFF_CHECK_EN to build the stuff-bit checker;
// otherwise stuff_err is tied low.
module rx_shift_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_POINT = 3,
  parameter int unsigned STUFF_LIMIT  = STUFF_LIMIT_DEFAULT
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable_timer,
  input  logic       d_edge,
  input  logic       d_orig,
  output logic       shift_enable,
  output logic       byte_received,
  output logic [3:0] bit_count,
  output logic       stuff_err
);

  localparam int unsigned OnesW = $clog2(STUFF_LIMIT + 1);
  localparam logic [OnesW-1:0] StuffMax = OnesW'(STUFF_LIMIT);
  localparam logic [3:0]       LastBit  = 4'(BYTE_BITS - 1);

  rx_ctrl_state_t   state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [OnesW-1:0] ones_q, ones_d;

  logic timer_active;
  logic sample;
  logic stuff_bit;
  logic data_bit;

  // Dropping enable_timer also clears the timer on that same edge.
  assign timer_active = (state_q != IDLE) && enable_timer;

  rx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SAMPLE_POINT (SAMPLE_POINT)
  ) u_bit_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .active (timer_active),
    .d_edge (d_edge),
    .sample (sample)
  );

  // The bit following STUFF_LIMIT data ones is a stuff bit and never shifts.
  assign stuff_bit = sample && (ones_q == StuffMax);
  assign data_bit  = sample && !stuff_bit;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    ones_d    = ones_q;

    unique case (state_q)
      IDLE: begin
        if (enable_timer) begin
          state_d = RUN;
        end
      end
      RUN, DONE: begin
        // DONE is a single-cycle marker; the bit timer keeps running through it.
        state_d = RUN;
        if (stuff_bit) begin
          ones_d = '0;
        end else if (data_bit) begin
          // Run length carries across byte boundaries.
          ones_d = d_orig ? (ones_q + OnesW'(1)) : '0;
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
            state_d   = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Losing enable discards any partial byte without a byte_received pulse.
    if (!enable_timer) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      ones_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      ones_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ones_q    <= ones_d;
    end
  end

  // Decoded from registered state only, so the strobe cannot glitch on
  // asynchronous input changes other than d_edge suppression.
  assign shift_enable  = data_bit;
  assign byte_received = (state_q == DONE);
  assign bit_count     = bit_cnt_q;

`ifdef RX_STUFF_CHECK_EN
  logic stuff_err_q, stuff_err_d;

  // A one where a stuff bit belongs is a violation; the flag stays set for
  // the rest of the packet. Sequencing is unaffected.
  always_comb begin
    stuff_err_d = stuff_err_q;
    if (!enable_timer) begin
      stuff_err_d = 1'b0;
    end else if (stuff_bit && d_orig) begin
      stuff_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stuff_err_q <= 1'b0;
    end else begin
      stuff_err_q <= stuff_err_d;
    end
  end

  assign stuff_err = stuff_err_q;
`else
  assign stuff_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_shift_ctrl.sv
// Self-checking bench for rx_shift_ctrl: directed bit streams plus randomised
// packets, compared every cycle against a behavioural model that tracks bit
// phase as elapsed time since the last alignment point and collects data bits
// in a queue.
module tb_rx_shift_ctrl;

  localparam int CPB   = 8;
  localparam int SP    = 3;
  localparam int STUFF = 6;

`ifdef RX_STUFF_CHECK_EN
  localparam bit StuffChk = 1'b1;
`else
  localparam bit StuffChk = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       enable_timer = 1'b0;
  logic       d_edge = 1'b0;
  logic       d_orig = 1'b0;
  logic       shift_enable;
  logic       byte_received;
  logic [3:0] bit_count;
  logic       stuff_err;

  always #5 clk = ~clk;

  rx_shift_ctrl #(
    .CLKS_PER_BIT (CPB),
    .SAMPLE_POINT (SP),
    .STUFF_LIMIT  (STUFF)
  ) u_dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .enable_timer  (enable_timer),
    .d_edge        (d_edge),
    .d_orig        (d_orig),
    .shift_enable  (shift_enable),
    .byte_received (byte_received),
    .bit_count     (bit_count),
    .stuff_err     (stuff_err)
  );

  // Stand-in for the downstream LSB-first shift register.
  logic [7:0] sr = 8'h00;
  int         n_shift = 0;
  always @(posedge clk) begin
    if (shift_enable) begin
      sr      <= {d_orig, sr[7:1]};
      n_shift <= n_shift + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  bit         m_run = 1'b0;
  bit         m_done = 1'b0;
  bit         m_err = 1'b0;
  int         m_anchor = 0;
  int         m_ones = 0;
  int         cyc = 0;
  bit         m_q[$];
  logic [7:0] m_byte = 8'h00;
  logic [7:0] got_byte = 8'h00;
  logic       line = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int phase();
    return (cyc - m_anchor) % CPB;
  endfunction

  task automatic model_clear();
    m_run  = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_ones = 0;
    m_q.delete();
  endtask

  // One clock: drive at the falling edge, compare, then advance the model.
  task automatic cycle(input logic en, input logic de, input logic d);
    bit smp;
    enable_timer = en;
    d_edge       = de;
    d_orig       = d;
    #1;
    smp = m_run && (phase() == SP) && !de;
    check("shift_enable", 32'(shift_enable), 32'(smp && (m_ones != STUFF)));
    check("byte_received", 32'(byte_received), 32'(m_done));
    check("bit_count", 32'(bit_count), 32'(m_q.size()));
    check("stuff_err", 32'(stuff_err), 32'(m_err));
    if (m_done) begin
      got_byte = sr;
      check("byte_value", 32'(sr), 32'(m_byte));
    end
    @(posedge clk);
    if (!en) begin
      model_clear();
    end else if (!m_run) begin
      m_run    = 1'b1;
      m_done   = 1'b0;
      m_anchor = cyc + 1;
    end else begin
      m_done = 1'b0;
      if (smp) begin
        if (m_ones == STUFF) begin
          if (StuffChk && d) m_err = 1'b1;
          m_ones = 0;
        end else begin
          m_q.push_back(d);
          m_ones = d ? m_ones + 1 : 0;
          if (m_q.size() == 8) begin
            for (int i = 0; i < 8; i++) m_byte[i] = m_q[i];
            m_q.delete();
            m_done = 1'b1;
          end
        end
      end
      if (de) m_anchor = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask

  // One bus bit of len clocks; d_edge on a real transition, plus an optional
  // spurious edge at offset spur.
  task automatic send_bit(input logic b, input int len, input int spur);
    for (int k = 0; k < len; k++) begin
      cycle(1'b1, ((k == 0) && (b != line)) || (k == spur), b);
    end
    line = b;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i], CPB, -1);
  endtask

  task automatic start();
    cycle(1'b1, 1'b0, line);
  endtask

  // Never drop enable on a sample cycle.
  task automatic drop(input int n);
    while (m_run && (phase() == SP)) cycle(1'b1, 1'b0, line);
    repeat (n) cycle(1'b0, 1'b0, line);
  endtask

  initial begin
    int n0;
    #1;
    check("rst_shift_enable", 32'(shift_enable), 32'd0);
    check("rst_byte_received", 32'(byte_received), 32'd0);
    check("rst_bit_count", 32'(bit_count), 32'd0);
    check("rst_stuff_err", 32'(stuff_err), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 1'b0);

    // Byte 0xA5 at nominal timing.
    got_byte = 8'h00;
    start();
    send_byte(8'hA5);
    drop(2);
    check("byte_a5", 32'(got_byte), 32'h0000_00A5);

    // Six ones, stuff zero, then a one: seven shifts.
    n0 = n_shift;
    start();
    repeat (6) send_bit(1'b1, CPB, -1);
    send_bit(1'b0, CPB, -1);
    send_bit(1'b1, CPB, -1);
    check("stuff_shift_cnt", 32'(n_shift - n0), 32'd7);
    check("stuff_bit_cnt", 32'(bit_count), 32'd7);
    drop(2);

    // Early edge, edge on the sample point, and a long bit.
    start();
    send_bit(1'b1, CPB, -1);
    send_bit(1'b0, 6, -1);
    send_bit(1'b1, CPB, 3);
    send_bit(1'b0, CPB, -1);
    send_bit(1'b1, 10, -1);
    send_bit(1'b1, CPB, -1);
    check("resync_bit_cnt", 32'(bit_count), 32'd6);
    drop(2);

    // Drop enable after four bits, then 0xFF with its stuff bit.
    start();
    send_bit(1'b1, CPB, -1);
    send_bit(1'b0, CPB, -1);
    send_bit(1'b1, CPB, -1);
    send_bit(1'b1, CPB, -1);
    check("pre_drop_cnt", 32'(bit_count), 32'd4);
    drop(1);
    check("drop_cnt", 32'(bit_count), 32'd0);
    got_byte = 8'h00;
    start();
    repeat (6) send_bit(1'b1, CPB, -1);
    send_bit(1'b0, CPB, -1);
    send_bit(1'b1, CPB, -1);
    send_bit(1'b1, CPB, -1);
    check("byte_ff", 32'(got_byte), 32'h0000_00FF);
    drop(2);

    // Stuff violation: a one where the stuff bit belongs.
    start();
    repeat (7) send_bit(1'b1, CPB, -1);
    send_bit(1'b0, CPB, -1);
    send_bit(1'b1, CPB, -1);
    check("stuff_err_set", 32'(stuff_err), 32'(StuffChk));
    drop(1);
    check("stuff_err_clr", 32'(stuff_err), 32'd0);

    // Asynchronous reset mid-byte.
    start();
    send_bit(1'b0, CPB, -1);
    send_bit(1'b1, CPB, -1);
    send_bit(1'b1, CPB, -1);
    send_bit(1'b0, CPB, -1);
    send_bit(1'b1, CPB, -1);
    check("pre_rst_cnt", 32'(bit_count), 32'd5);
    #3;
    n_rst = 1'b0;
    #1;
    check("arst_shift_enable", 32'(shift_enable), 32'd0);
    check("arst_byte_received", 32'(byte_received), 32'd0);
    check("arst_bit_count", 32'(bit_count), 32'd0);
    check("arst_stuff_err", 32'(stuff_err), 32'd0);
    model_clear();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    n_rst = 1'b1;
    start();
    send_byte(8'h3C);
    drop(1);

    // Randomised packets with jittered bit lengths and spurious edges.
    for (int s = 0; s < 40; s++) begin
      int nb;
      start();
      nb = int'($urandom_range(4, 24));
      for (int i = 0; i < nb; i++) begin
        int   len;
        int   spur;
        logic b;
        b    = ($urandom_range(0, 3) != 0);
        len  = int'($urandom_range(6, 10));
        spur = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, len - 1)) : -1;
        send_bit(b, len, spur);
      end
      drop(int'($urandom_range(1, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
